// File: rtl/mem_pkg.sv
// Shared ExtMem request types, field widths and command encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  localparam logic [4:0] M_XRD  = 5'd0;
  localparam logic [4:0] M_XWR  = 5'd1;

  localparam int ADDR_W = 40;
  localparam int DATA_W = 64;
  localparam int CMD_W  = 5;
  localparam int TYP_W  = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CMD_W-1:0]  cmd;
    logic [TYP_W-1:0]  typ;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/id_fifo.sv
// Synchronous FIFO of requester IDs for requests still awaiting a response.
// Latency: head visible combinationally (pop_data); push/pop take effect at the next edge.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
// Ports: clk, reset (sync, active-low), push/push_data, pop/pop_data, full, empty, count.
module id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the single ExtMem port among NREQ requesters; in-order responses routed by ID FIFO.
// Latency: request on mem_req_* 1 cycle after grant, 2 cycles min per request; response 1 cycle after mem_resp.
// Backpressure: payload held until mem_req_ready_i; no grant while MAXOUT responses are outstanding.
// Ports: clk, reset (sync, active-low); rq_* requester side (packed per requester), rs_* response side,
//        mem_req_*/mem_resp_* ExtMem pins, err_o (sticky orphan response), busy_o.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int MAXOUT  = 4,
  parameter int WR_RESP = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          rq_valid_i,
  output logic [NREQ-1:0]          rq_ready_o,
  input  logic [NREQ*ADDR_W-1:0]   rq_addr_i,
  input  logic [NREQ*CMD_W-1:0]    rq_cmd_i,
  input  logic [NREQ*TYP_W-1:0]    rq_typ_i,
  input  logic [NREQ*DATA_W-1:0]   rq_data_i,
  output logic [NREQ-1:0]          rs_valid_o,
  output logic [DATA_W-1:0]        rs_data_o,
  input  logic                     mem_req_ready_i,
  output logic                     mem_req_valid_o,
  output logic [ADDR_W-1:0]        mem_req_addr_o,
  output logic [CMD_W-1:0]         mem_req_cmd_o,
  output logic [TYP_W-1:0]         mem_req_typ_o,
  output logic [DATA_W-1:0]        mem_req_data_o,
  input  logic                     mem_resp_valid_i,
  input  logic [DATA_W-1:0]        mem_resp_data_i,
  output logic                     err_o,
  output logic                     busy_o
);

  localparam int ID_W = $clog2(NREQ);

  arb_state_t            state_q;
  arb_state_t            state_d;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       gnt_q;
  logic [ID_W-1:0]       pick;
  mem_req_t              req_q;
  mem_req_t              req_sel;
  logic                  load;
  logic                  hs;
  logic                  resp_exp;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [ID_W-1:0]       fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(MAXOUT):0] fifo_count;
  logic [NREQ-1:0]       rs_onehot;

  // First valid requester at or after p, wrapping. Scanning downwards lets the
  // closest-to-p candidate overwrite any later one.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] vld,
                                              input logic [ID_W-1:0] p);
    logic [ID_W-1:0] sel;
    int              k;
    sel = p;
    for (int i = NREQ-1; i >= 0; i--) begin
      k = int'(p) + i;
      if (k >= NREQ) k = k - NREQ;
      if (vld[k]) sel = ID_W'(k);
    end
    return sel;
  endfunction

  assign pick = rr_pick(rq_valid_i, ptr_q);

  always_comb begin
    req_sel.addr = rq_addr_i[int'(pick)*ADDR_W +: ADDR_W];
    req_sel.cmd  = rq_cmd_i [int'(pick)*CMD_W  +: CMD_W];
    req_sel.typ  = rq_typ_i [int'(pick)*TYP_W  +: TYP_W];
    req_sel.data = rq_data_i[int'(pick)*DATA_W +: DATA_W];
  end

  // Arbitration FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration FSM: next state and handshake strobes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    hs      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if ((|rq_valid_i) && !fifo_full) begin
          load    = 1'b1;
          state_d = ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        if (mem_req_ready_i) begin
          hs      = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    rq_ready_o = '0;
    if (hs) rq_ready_o[gnt_q] = 1'b1;
  end

  // Grant ID, payload and round-robin pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_q <= '0;
      req_q <= '0;
      ptr_q <= '0;
    end else begin
      if (load) begin
        gnt_q <= pick;
        req_q <= req_sel;
      end
      if (hs) begin
        ptr_q <= (gnt_q == ID_W'(NREQ-1)) ? '0 : gnt_q + 1'b1;
      end
    end
  end

  assign mem_req_valid_o = (state_q == ARB_HOLD);
  assign mem_req_addr_o  = req_q.addr;
  assign mem_req_cmd_o   = req_q.cmd;
  assign mem_req_typ_o   = req_q.typ;
  assign mem_req_data_o  = req_q.data;

  // With WR_RESP=0 only reads produce a response, so only reads are tracked.
  assign resp_exp  = (WR_RESP != 0) || (req_q.cmd == M_XRD);
  assign fifo_push = hs && resp_exp;
  assign fifo_pop  = mem_resp_valid_i && !fifo_empty;

  id_fifo #(
    .DEPTH (MAXOUT),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (gnt_q),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rs_onehot = '0;
    if (fifo_pop) rs_onehot[fifo_head] = 1'b1;
  end

  // Response register; an orphan response is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rs_valid_o <= '0;
      rs_data_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      rs_valid_o <= rs_onehot;
      if (fifo_pop) rs_data_o <= mem_resp_data_i;
      if (mem_resp_valid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  assign busy_o = (state_q == ARB_HOLD) || (fifo_count != '0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with grant and response scoreboards.
// Latency: checks grant order, hold stability, 1-cycle response latency.
// Backpressure: exercises ExtMem stall, FIFO-full blocking and orphan responses.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int NREQ   = 3;
  localparam int MAXOUT = 4;

  typedef struct {
    int          id;
    logic [39:0] addr;
    logic [4:0]  cmd;
    logic [2:0]  typ;
    logic [63:0] data;
  } req_ent_t;

  typedef struct {
    int          id;
    logic [63:0] data;
    int          due;
  } rsp_ent_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   rq_valid_i = '0;
  logic [NREQ-1:0]   rq_ready_o;
  logic [NREQ*40-1:0] rq_addr_i = '0;
  logic [NREQ*5-1:0]  rq_cmd_i = '0;
  logic [NREQ*3-1:0]  rq_typ_i = '0;
  logic [NREQ*64-1:0] rq_data_i = '0;
  logic [NREQ-1:0]   rs_valid_o;
  logic [63:0]       rs_data_o;
  logic              mem_req_ready_i = 1'b1;
  logic              mem_req_valid_o;
  logic [39:0]       mem_req_addr_o;
  logic [4:0]        mem_req_cmd_o;
  logic [2:0]        mem_req_typ_o;
  logic [63:0]       mem_req_data_o;
  logic              mem_resp_valid_i = 1'b0;
  logic [63:0]       mem_resp_data_i = '0;
  logic              err_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int hs_per [NREQ];
  logic [NREQ-1:0] last_ready = '0;

  req_ent_t q0[$], q1[$], q2[$];
  req_ent_t exp_gnt[$];
  rsp_ent_t exp_rsp[$];

  mem_port_arbiter #(.NREQ(NREQ), .MAXOUT(MAXOUT), .WR_RESP(1)) dut (
    .clk(clk), .reset(reset),
    .rq_valid_i(rq_valid_i), .rq_ready_o(rq_ready_o),
    .rq_addr_i(rq_addr_i), .rq_cmd_i(rq_cmd_i), .rq_typ_i(rq_typ_i), .rq_data_i(rq_data_i),
    .rs_valid_o(rs_valid_o), .rs_data_o(rs_data_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_cmd_o(mem_req_cmd_o),
    .mem_req_typ_o(mem_req_typ_o), .mem_req_data_o(mem_req_data_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic next_req(input int r, output bit ok, output req_ent_t e);
    ok = 1'b0;
    e = '{id: 0, addr: '0, cmd: '0, typ: '0, data: '0};
    case (r)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Push order equals the round-robin grant order the bench expects.
  task automatic add_req(input int r, input logic [39:0] a, input logic [4:0] c,
                         input logic [2:0] t, input logic [63:0] d);
    req_ent_t e;
    e = '{id: r, addr: a, cmd: c, typ: t, data: d};
    case (r)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    exp_gnt.push_back(e);
  endtask

  // Requester model: holds valid/payload until its ready pulse, then loads the next one.
  always @(posedge clk) begin
    bit ok;
    req_ent_t e;
    #1;
    for (int r = 0; r < NREQ; r++) begin
      if (!rq_valid_i[r] || last_ready[r]) begin
        next_req(r, ok, e);
        if (ok) begin
          rq_valid_i[r]           = 1'b1;
          rq_addr_i[r*40 +: 40]   = e.addr;
          rq_cmd_i[r*5 +: 5]      = e.cmd;
          rq_typ_i[r*3 +: 3]      = e.typ;
          rq_data_i[r*64 +: 64]   = e.data;
        end else begin
          rq_valid_i[r] = 1'b0;
        end
      end
    end
  end

  // Monitor: grant and response scoreboards, sampled mid-cycle.
  always @(negedge clk) begin
    req_ent_t g;
    rsp_ent_t s;
    last_ready = rq_ready_o;
    if (mem_req_valid_o && mem_req_ready_i) begin
      hs_cnt++;
      for (int r = 0; r < NREQ; r++) if (rq_ready_o[r]) hs_per[r]++;
      if (exp_gnt.size() == 0) begin
        chk("gnt_unexpected", 64'(exp_gnt.size()), 64'd1);
      end else begin
        g = exp_gnt.pop_front();
        chk("gnt_ready", 64'(rq_ready_o), 64'(oh(g.id)));
        chk("gnt_addr",  64'(mem_req_addr_o), 64'(g.addr));
        chk("gnt_cmd",   64'(mem_req_cmd_o), 64'(g.cmd));
        chk("gnt_typ",   64'(mem_req_typ_o), 64'(g.typ));
        chk("gnt_data",  mem_req_data_o, g.data);
      end
    end else if (rq_ready_o != '0) begin
      chk("ready_outside_hs", 64'(rq_ready_o), 64'd0);
    end
    if (rs_valid_o != '0) begin
      if (exp_rsp.size() == 0) begin
        chk("rsp_unexpected", 64'(rs_valid_o), 64'd0);
      end else begin
        s = exp_rsp.pop_front();
        chk("rsp_owner",   64'(rs_valid_o), 64'(oh(s.id)));
        chk("rsp_data",    rs_data_o, s.data);
        chk("rsp_latency", 64'(cyc), 64'(s.due));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_valid", 64'(mem_req_valid_o), 64'd0);
    chk("rst_rq_ready",  64'(rq_ready_o), 64'd0);
    chk("rst_rs_valid",  64'(rs_valid_o), 64'd0);
    chk("rst_rs_data",   rs_data_o, 64'd0);
    chk("rst_err",       64'(err_o), 64'd0);
    chk("rst_busy",      64'(busy_o), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int target, input int budget, input string tag);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, 64'(hs_cnt >= target), 64'd1);
  endtask

  // Called at posedge+1; drives one response cycle and records the expected result.
  task automatic send_rsp(input logic [63:0] d, input int id, input bit expect_out);
    if (expect_out) exp_rsp.push_back('{id: id, data: d, due: cyc + 1});
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = d;
    @(posedge clk); #1;
    mem_resp_valid_i = 1'b0;
  endtask

  initial begin
    int hs0;
    int base [NREQ];
    for (int r = 0; r < NREQ; r++) hs_per[r] = 0;
    do_reset();

    // 1: single read from requester 0
    add_req(0, 40'h10, M_XRD, 3'd1, 64'h0);
    wait_hs(1, 20, "t1_issue");
    chk("t1_busy_inflight", 64'(busy_o), 64'd1);
    tick(2);
    send_rsp(64'hAB, 0, 1'b1);
    tick(3);
    chk("t1_busy_done", 64'(busy_o), 64'd0);

    // 2: all three requesters continuously valid
    do_reset();
    for (int r = 0; r < NREQ; r++) base[r] = hs_per[r];
    hs0 = hs_cnt;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NREQ; r++)
        add_req(r, 40'h1000 * (r + 1) + 40'(k), M_XRD, 3'(r + k), 64'h100 + 64'(r));
    wait_hs(hs0 + 4, 40, "t2_fill");
    send_rsp(64'hC0, 0, 1'b1);
    send_rsp(64'hC1, 1, 1'b1);
    send_rsp(64'hC2, 2, 1'b1);
    send_rsp(64'hC3, 0, 1'b1);
    wait_hs(hs0 + 6, 40, "t2_rest");
    send_rsp(64'hC4, 1, 1'b1);
    send_rsp(64'hC5, 2, 1'b1);
    tick(3);
    for (int r = 0; r < NREQ; r++) chk("t2_pulses", 64'(hs_per[r] - base[r]), 64'd2);

    // 3: ExtMem stalls for 5 cycles while a write is held
    do_reset();
    mem_req_ready_i = 1'b0;
    hs0 = hs_cnt;
    add_req(1, 40'hABC, M_XWR, 3'd2, 64'hDEAD_BEEF);
    for (int n = 0; n < 20 && !mem_req_valid_o; n++) tick(1);
    chk("t3_hold_valid", 64'(mem_req_valid_o), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("t3_addr", 64'(mem_req_addr_o), 64'hABC);
      chk("t3_cmd",  64'(mem_req_cmd_o), 64'(M_XWR));
      chk("t3_data", mem_req_data_o, 64'hDEAD_BEEF);
      chk("t3_no_ready", 64'(rq_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    mem_req_ready_i = 1'b1;
    wait_hs(hs0 + 1, 10, "t3_release");
    send_rsp(64'h77, 1, 1'b1);
    tick(3);

    // 4: MAXOUT outstanding reads block the fifth
    do_reset();
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) add_req(0, 40'h40 + 40'(i), M_XRD, 3'd0, 64'h0);
    wait_hs(hs0 + 4, 40, "t4_fill");
    repeat (6) begin
      @(negedge clk);
      chk("t4_blocked", 64'(mem_req_valid_o), 64'd0);
      chk("t4_busy", 64'(busy_o), 64'd1);
    end
    @(posedge clk); #1;
    chk("t4_count_held", 64'(hs_cnt), 64'(hs0 + 4));
    send_rsp(64'h4000, 0, 1'b1);
    wait_hs(hs0 + 5, 20, "t4_fifth");
    for (int i = 1; i < 5; i++) send_rsp(64'h4000 + 64'(i), 0, 1'b1);
    tick(4);
    chk("t4_idle", 64'(busy_o), 64'd0);

    // 5: req1 read, req2 write, in-order responses
    do_reset();
    hs0 = hs_cnt;
    add_req(1, 40'h111, M_XRD, 3'd3, 64'h0);
    add_req(2, 40'h222, M_XWR, 3'd4, 64'h5555);
    wait_hs(hs0 + 2, 20, "t5_issue");
    send_rsp(64'hD1D1, 1, 1'b1);
    send_rsp(64'hD2D2, 2, 1'b1);
    tick(3);
    chk("t5_no_err", 64'(err_o), 64'd0);

    // 6: orphan response sets sticky error; one-cycle reset clears it
    send_rsp(64'hEE, 0, 1'b0);
    chk("t6_err_set", 64'(err_o), 64'd1);
    tick(4);
    chk("t6_err_sticky", 64'(err_o), 64'd1);
    do_reset();
    chk("t6_err_cleared", 64'(err_o), 64'd0);

    tick(2);
    chk("gnt_drained", 64'(exp_gnt.size()), 64'd0);
    chk("rsp_drained", 64'(exp_rsp.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
